// File: rtl/fpu_sequencer.sv
// Sequences one operation at a time through an external multi-cycle FPU.
// Registers operands and controls, counts the op latency, captures the result.
//
// Ports:
//   clk, rst (sync, active-low)
//   issue, funct5, rm, rs1_val, rs2_val : E-stage request
//   kill : flush, hold : downstream stall
//   fpu_result : combinational FPU output
//   fpu_rd1/rd2/rm/funct5 : registered FPU inputs
//   fpu_stall, result, result_valid, busy
module fpu_sequencer #(
   parameter int unsigned LAT_ADD  = 2,
   parameter int unsigned LAT_MUL  = 2,
   parameter int unsigned LAT_DIV  = 8,
   parameter int unsigned LAT_SQRT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue,
   input  logic [4:0]  funct5,
   input  logic [2:0]  rm,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic        kill,
   input  logic        hold,
   input  logic [31:0] fpu_result,
   output logic [31:0] fpu_rd1,
   output logic [31:0] fpu_rd2,
   output logic [2:0]  fpu_rm,
   output logic [4:0]  fpu_funct5,
   output logic        fpu_stall,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy
);

   localparam logic [3:0] L_ADD  = LAT_ADD[3:0];
   localparam logic [3:0] L_MUL  = LAT_MUL[3:0];
   localparam logic [3:0] L_DIV  = LAT_DIV[3:0];
   localparam logic [3:0] L_SQRT = LAT_SQRT[3:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rd1_q, rd1_d;
   logic [31:0] rd2_q, rd2_d;
   logic [2:0]  rm_q, rm_d;
   logic [4:0]  f5_q, f5_d;
   logic [31:0] result_q, result_d;

   logic [3:0]  lat;
   logic        accept;

   always_comb begin
      lat = 4'd1;
      case (funct5)
         5'b00000, 5'b00001: lat = L_ADD;
         5'b00010:           lat = L_MUL;
         5'b00011:           lat = L_DIV;
         5'b01011:           lat = L_SQRT;
         default:            lat = 4'd1;
      endcase
   end

   assign accept = issue & ~kill &
                   ((state_q == IDLE) | ((state_q == DONE) & ~hold));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;
      rm_d     = rm_q;
      f5_d     = f5_q;
      result_d = result_q;

      case (state_q)
         IDLE: state_d = IDLE;
         EXEC: begin
            // cnt of 0 cannot occur legally; treat it as finished anyway
            if (cnt_q <= 4'd1) begin
               result_d = fpu_result;
               cnt_d    = 4'd0;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (!hold) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // back-to-back accept from DONE overrides the return to IDLE
      if (accept) begin
         rd1_d   = rs1_val;
         rd2_d   = rs2_val;
         rm_d    = rm;
         f5_d    = funct5;
         cnt_d   = lat;
         state_d = EXEC;
      end

      if (kill) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         rd1_q    <= 32'd0;
         rd2_q    <= 32'd0;
         rm_q     <= 3'd0;
         f5_q     <= 5'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         rm_q     <= rm_d;
         f5_q     <= f5_d;
         result_q <= result_d;
      end
   end

   assign fpu_rd1      = rd1_q;
   assign fpu_rd2      = rd2_q;
   assign fpu_rm       = rm_q;
   assign fpu_funct5   = f5_q;
   assign result       = result_q;
   assign result_valid = (state_q == DONE);
   assign busy         = (state_q != IDLE);

   // forced low during reset so the pipeline is never held by a stale op
   assign fpu_stall = rst &
                      ((issue & (state_q == IDLE)) |
                       (state_q == EXEC) |
                       (issue & (state_q == DONE) & hold));

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed self-checking bench for fpu_sequencer.
// Inputs change 2ns after the rising edge, outputs are checked 3ns later.
module tb_fpu_sequencer;

   logic        clk;
   logic        rst;
   logic        issue;
   logic [4:0]  funct5;
   logic [2:0]  rm;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        kill;
   logic        hold;
   logic [31:0] fpu_result;
   logic [31:0] fpu_rd1;
   logic [31:0] fpu_rd2;
   logic [2:0]  fpu_rm;
   logic [4:0]  fpu_funct5;
   logic        fpu_stall;
   logic [31:0] result;
   logic        result_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fpu_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .issue        (issue),
      .funct5       (funct5),
      .rm           (rm),
      .rs1_val      (rs1_val),
      .rs2_val      (rs2_val),
      .kill         (kill),
      .hold         (hold),
      .fpu_result   (fpu_result),
      .fpu_rd1      (fpu_rd1),
      .fpu_rd2      (fpu_rd2),
      .fpu_rm       (fpu_rm),
      .fpu_funct5   (fpu_funct5),
      .fpu_stall    (fpu_stall),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FPU model: real fadd answer for the 1.0+2.0 case, else a tag of operands
   assign fpu_result =
      (fpu_funct5 == 5'd0 && fpu_rd1 == 32'h3F800000 &&
       fpu_rd2 == 32'h40000000) ? 32'h40400000 :
      (fpu_rd1 ^ fpu_rd2 ^ {27'd0, fpu_funct5});

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [4:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] r);
      issue   = 1'b1;
      funct5  = f;
      rs1_val = a;
      rs2_val = b;
      rm      = r;
   endtask

   initial begin
      rst = 1'b0; issue = 1'b0; funct5 = 5'd0; rm = 3'd0;
      rs1_val = 32'd0; rs2_val = 32'd0; kill = 1'b0; hold = 1'b0;

      // reset state, stall masked while in reset
      cyc(); cyc();
      issue = 1'b1;
      #3;
      chk("rst_stall", {31'd0, fpu_stall}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rv", {31'd0, result_valid}, 32'd0);
      chk("rst_rd1", fpu_rd1, 32'd0);
      chk("rst_res", result, 32'd0);

      // fadd accepted in first cycle out of reset: T
      cyc();
      rst = 1'b1;
      req(5'd0, 32'h3F800000, 32'h40000000, 3'd2);
      #3;
      chk("fadd_T_stall", {31'd0, fpu_stall}, 32'd1);
      chk("fadd_T_busy", {31'd0, busy}, 32'd0);
      cyc(); issue = 1'b0; #3;
      chk("fadd_T1_stall", {31'd0, fpu_stall}, 32'd1);
      chk("fadd_T1_rd1", fpu_rd1, 32'h3F800000);
      chk("fadd_T1_rd2", fpu_rd2, 32'h40000000);
      chk("fadd_T1_rm", {29'd0, fpu_rm}, 32'd2);
      chk("fadd_T1_rv", {31'd0, result_valid}, 32'd0);
      cyc(); #3;
      chk("fadd_T2_stall", {31'd0, fpu_stall}, 32'd1);
      chk("fadd_T2_rv", {31'd0, result_valid}, 32'd0);
      cyc(); #3;
      chk("fadd_T3_rv", {31'd0, result_valid}, 32'd1);
      chk("fadd_T3_res", result, 32'h40400000);
      chk("fadd_T3_stall", {31'd0, fpu_stall}, 32'd0);
      cyc(); #3;
      chk("fadd_T4_busy", {31'd0, busy}, 32'd0);
      chk("fadd_T4_rv", {31'd0, result_valid}, 32'd0);

      // fmul with hold for 4 cycles in DONE
      cyc();
      req(5'd2, 32'h000000F0, 32'h00000F00, 3'd1);
      cyc(); issue = 1'b0;
      cyc();
      cyc(); hold = 1'b1; #3;
      chk("hold_T3_rv", {31'd0, result_valid}, 32'd1);
      chk("hold_T3_res", result, 32'h00000FF2);
      cyc(); #3;
      chk("hold_T4_rv", {31'd0, result_valid}, 32'd1);
      cyc();
      req(5'd3, 32'h1, 32'h2, 3'd0);
      #3;
      chk("hold_T5_stall", {31'd0, fpu_stall}, 32'd1);
      cyc(); issue = 1'b0; #3;
      chk("hold_T6_rv", {31'd0, result_valid}, 32'd1);
      chk("hold_T6_res", result, 32'h00000FF2);
      chk("hold_T6_f5", {27'd0, fpu_funct5}, 32'd2);
      cyc(); hold = 1'b0; #3;
      chk("hold_T7_rv", {31'd0, result_valid}, 32'd1);
      chk("hold_T7_stall", {31'd0, fpu_stall}, 32'd0);
      cyc(); #3;
      chk("hold_T8_rv", {31'd0, result_valid}, 32'd0);
      chk("hold_T8_busy", {31'd0, busy}, 32'd0);

      // fdiv then back-to-back fmul
      cyc();
      req(5'd3, 32'h00000100, 32'h00000010, 3'd4);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 4) req(5'd2, 32'h0000000A, 32'h00000005, 3'd0);
         else if (k < 4) issue = 1'b0;
         #3;
         chk($sformatf("div_T%0d_stall", k), {31'd0, fpu_stall}, 32'd1);
         chk($sformatf("div_T%0d_rv", k), {31'd0, result_valid}, 32'd0);
         chk($sformatf("div_T%0d_f5", k), {27'd0, fpu_funct5}, 32'd3);
      end
      cyc(); #3;
      chk("div_T9_rv", {31'd0, result_valid}, 32'd1);
      chk("div_T9_res", result, 32'h00000113);
      chk("div_T9_stall", {31'd0, fpu_stall}, 32'd0);
      cyc(); issue = 1'b0; #3;
      chk("b2b_T10_rv", {31'd0, result_valid}, 32'd0);
      chk("b2b_T10_busy", {31'd0, busy}, 32'd1);
      chk("b2b_T10_f5", {27'd0, fpu_funct5}, 32'd2);
      chk("b2b_T10_rd1", fpu_rd1, 32'h0000000A);
      cyc(); #3;
      chk("b2b_T11_rv", {31'd0, result_valid}, 32'd0);
      cyc(); #3;
      chk("b2b_T12_rv", {31'd0, result_valid}, 32'd1);
      chk("b2b_T12_res", result, 32'h0000000D);
      cyc(); #3;
      chk("b2b_T13_busy", {31'd0, busy}, 32'd0);

      // kill at cnt=5 with a simultaneous issue
      cyc();
      req(5'd3, 32'h00001000, 32'h00002000, 3'd0);
      cyc(); issue = 1'b0;
      cyc(); cyc(); cyc();
      kill = 1'b1;
      req(5'd0, 32'h1, 32'h1, 3'd0);
      cyc(); kill = 1'b0; issue = 1'b0; #3;
      chk("kill_busy", {31'd0, busy}, 32'd0);
      chk("kill_rv", {31'd0, result_valid}, 32'd0);
      chk("kill_stall", {31'd0, fpu_stall}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         cyc(); #3;
         chk($sformatf("kill_after%0d_rv", k),
             {31'd0, result_valid}, 32'd0);
      end

      // 1-cycle fsgnj
      cyc();
      req(5'd4, 32'h80000000, 32'h00000001, 3'd0);
      cyc(); issue = 1'b0; #3;
      chk("sgnj_T1_stall", {31'd0, fpu_stall}, 32'd1);
      chk("sgnj_T1_rv", {31'd0, result_valid}, 32'd0);
      cyc(); #3;
      chk("sgnj_T2_rv", {31'd0, result_valid}, 32'd1);
      chk("sgnj_T2_res", result, 32'h80000005);
      cyc(); #3;
      chk("sgnj_T3_busy", {31'd0, busy}, 32'd0);

      // reset pulse during EXEC
      cyc();
      req(5'd3, 32'h12345678, 32'h9ABCDEF0, 3'd7);
      cyc();
      rst = 1'b0;
      #3;
      chk("rstx_stall", {31'd0, fpu_stall}, 32'd0);
      cyc(); rst = 1'b1; issue = 1'b0; #3;
      chk("rstx_busy", {31'd0, busy}, 32'd0);
      chk("rstx_rv", {31'd0, result_valid}, 32'd0);
      chk("rstx_res", result, 32'd0);
      chk("rstx_rd1", fpu_rd1, 32'd0);
      chk("rstx_rd2", fpu_rd2, 32'd0);
      chk("rstx_rm", {29'd0, fpu_rm}, 32'd0);
      chk("rstx_f5", {27'd0, fpu_funct5}, 32'd0);
      chk("rstx_stall2", {31'd0, fpu_stall}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
